phv_parser: RTL and testbench

//  Upstream neighbour of the RMT stage pipeline: sinks AXI-Stream packets, captures the first
//  64 header bytes, fills 24 PHV containers per a runtime-loaded parse table, and emits one PHV
//  per packet into stage 0 (phv_in/phv_in_valid). Payload forwarding is done elsewhere.

---
 rtl/phv_parser_pkg.sv | 67 ++++++
 rtl/phv_parser_if.sv | 17 +
 rtl/phv_parser_extract.sv | 34 +++
 rtl/phv_parser.sv | 166 ++++++++++++++++
 tb/tb_phv_parser.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/phv_parser_pkg.sv
// Shared definitions for the PHV parser: stream geometry, container layout,
// parse-table field widths, FSM encoding and small arithmetic helpers.
package phv_parser_pkg;

    // Stream geometry
    localparam int AXIS_DATA_W   = 256;
    localparam int AXIS_KEEP_W   = AXIS_DATA_W / 8;
    localparam int AXIS_USER_W   = 128;
    localparam int KEEP_CNT_W    = $clog2(AXIS_KEEP_W + 1);

    // Header window: the first two beats of each packet
    localparam int HDR_WIN_BYTES = 64;

    // Container groups: 8 x 48b, 8 x 32b, 8 x 16b
    localparam int N_C48         = 8;
    localparam int N_C32         = 8;
    localparam int N_C16         = 8;
    localparam int N_CONT        = N_C48 + N_C32 + N_C16;
    localparam int C48_BYTES     = 6;
    localparam int C32_BYTES     = 4;
    localparam int C16_BYTES     = 2;
    localparam int C48_BITS      = N_C48 * C48_BYTES * 8;
    localparam int C32_BITS      = N_C32 * C32_BYTES * 8;
    localparam int C16_BITS      = N_C16 * C16_BYTES * 8;

    // Tail of the PHV: reserved zero field and the metadata block
    localparam int PAD_BITS      = 100;
    localparam int META_BITS     = 256;
    localparam int LEN_W         = 16;
    localparam int PHV_BITS      = C48_BITS + C32_BITS + C16_BITS + PAD_BITS + META_BITS;

    // Parse-table write port
    localparam int CFG_ADDR_W    = 5;
    localparam int CFG_OFF_W     = 6;
    localparam int CFG_DATA_W    = CFG_OFF_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2,
        ST_EMIT = 2'd3
    } state_t;

    typedef struct packed {
        logic                 vld;
        logic [CFG_OFF_W-1:0] off;
    } cfg_entry_t;

    // Number of enabled bytes in one beat
    function automatic logic [KEEP_CNT_W-1:0] keep_count(input logic [AXIS_KEEP_W-1:0] keep);
        logic [KEEP_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < AXIS_KEEP_W; i++) begin
            cnt = cnt + KEEP_CNT_W'(keep[i]);
        end
        return cnt;
    endfunction

    // Packet length accumulation, pinned at all-ones instead of wrapping
    function automatic logic [LEN_W-1:0] sat_add_len(input logic [LEN_W-1:0] len,
                                                    input logic [KEEP_CNT_W-1:0] inc);
        logic [LEN_W:0] sum;
        sum = {1'b0, len} + (LEN_W+1)'(inc);
        return sum[LEN_W] ? {LEN_W{1'b1}} : sum[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/phv_parser_if.sv
// AXI-Stream bundle feeding the PHV parser.
interface phv_parser_if
    import phv_parser_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W,
    parameter int USER_W = AXIS_USER_W
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/phv_parser_extract.sv
// Pulls one W_BYTES-wide container out of the header window. The byte at the
// configured offset becomes the container MSB (network order); bytes that fall
// past the end of the window, or a disabled entry, read as zero.
module phv_parser_extract
    import phv_parser_pkg::*;
#(
    parameter int W_BYTES   = C48_BYTES,
    parameter int WIN_BYTES = HDR_WIN_BYTES
) (
    input  logic [WIN_BYTES*8-1:0] i_hdr,
    input  logic                   i_en,
    input  logic [CFG_OFF_W-1:0]   i_off,
    output logic [W_BYTES*8-1:0]   o_field
);

    logic [7:0] w_win [WIN_BYTES];

    for (genvar b = 0; b < WIN_BYTES; b++) begin : g_win
        assign w_win[b] = i_hdr[b*8 +: 8];
    end

    // Gather the field bytes from offset upward, zeroing anything outside the window
    always_comb begin
        o_field = '0;
        for (int j = 0; j < W_BYTES; j++) begin
            logic [CFG_OFF_W:0] v_idx;
            v_idx = {1'b0, i_off} + (CFG_OFF_W+1)'(j);
            if (i_en && (int'(v_idx) < WIN_BYTES)) begin
                o_field[(W_BYTES-1-j)*8 +: 8] = w_win[v_idx[CFG_OFF_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/phv_parser.sv
// PHV parser: accepts AXI-Stream packets, keeps the first 64 header bytes,
// fills 24 containers from a runtime parse table and emits one PHV per packet.
module phv_parser
    import phv_parser_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = AXIS_DATA_W,
    parameter int C_S_AXIS_TUSER_WIDTH = AXIS_USER_W,
    parameter int PHV_LEN              = PHV_BITS,
    parameter int HDR_BYTES            = HDR_WIN_BYTES
) (
    input  logic                  axis_clk,
    input  logic                  aresetn,
    phv_parser_if.slave           s_axis,
    input  logic                  parse_cfg_wr,
    input  logic [CFG_ADDR_W-1:0] parse_cfg_addr,
    input  logic [CFG_DATA_W-1:0] parse_cfg_data,
    output logic [PHV_LEN-1:0]    phv_out,
    output logic                  phv_valid_out
);

    localparam int HALF_W = C_S_AXIS_DATA_WIDTH;
    localparam int HDR_W  = HDR_BYTES * 8;
    localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int META_Z = META_BITS - LEN_W - C_S_AXIS_TUSER_WIDTH;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic                            r_run;
    logic                            w_ready;
    logic                            w_emit;
    logic                            w_beat;
    logic [C_S_AXIS_DATA_WIDTH-1:0]  w_beat_data;
    logic [KEEP_CNT_W-1:0]           w_beat_cnt;
    logic [HDR_W-1:0]                r_hdr;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] r_tuser;
    logic [LEN_W-1:0]                r_len;
    cfg_entry_t                      r_cfg [N_CONT];
    logic [C48_BITS-1:0]             w_c48;
    logic [C32_BITS-1:0]             w_c32;
    logic [C16_BITS-1:0]             w_c16;
    logic [PHV_LEN-1:0]              w_phv;

    assign w_beat        = s_axis.tvalid & w_ready;
    assign s_axis.tready = w_ready;
    assign w_beat_cnt    = keep_count(s_axis.tkeep);

    // FSM state register; r_run keeps tready low until the first clock after reset release
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
        end
    end

    // FSM next state: any accepted tlast beat goes straight to EMIT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_beat) w_state_nxt = s_axis.tlast ? ST_EMIT : ST_HDR;
            ST_HDR:  if (w_beat) w_state_nxt = s_axis.tlast ? ST_EMIT : ST_BODY;
            ST_BODY: if (w_beat && s_axis.tlast) w_state_nxt = ST_EMIT;
            ST_EMIT: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: accept beats everywhere except the single EMIT bubble
    always_comb begin
        w_ready = 1'b0;
        w_emit  = 1'b0;
        case (r_state)
            ST_IDLE, ST_HDR, ST_BODY: w_ready = r_run;
            ST_EMIT:                  w_emit  = 1'b1;
            default:                  w_ready = 1'b0;
        endcase
    end

    // Zero the data bytes whose tkeep bit is clear before they reach the header store
    always_comb begin
        w_beat_data = '0;
        for (int b = 0; b < KEEP_W; b++) begin
            w_beat_data[b*8 +: 8] = s_axis.tkeep[b] ? s_axis.tdata[b*8 +: 8] : 8'h00;
        end
    end

    // Header capture (beats 0 and 1), sideband latch and saturating byte count
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_hdr   <= '0;
            r_tuser <= '0;
            r_len   <= '0;
        end else if (w_beat) begin
            case (r_state)
                ST_IDLE: begin
                    r_hdr[HALF_W-1:0]     <= w_beat_data;
                    r_hdr[HDR_W-1:HALF_W] <= '0;
                    r_tuser               <= s_axis.tuser;
                    r_len                 <= LEN_W'(w_beat_cnt);
                end
                ST_HDR: begin
                    r_hdr[HDR_W-1:HALF_W] <= w_beat_data;
                    r_len                 <= sat_add_len(r_len, w_beat_cnt);
                end
                default: r_len <= sat_add_len(r_len, w_beat_cnt);
            endcase
        end
    end

    // Parse table: one {valid, offset} entry per container, used by extraction from the next cycle
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_CONT; i++) begin
                r_cfg[i] <= '0;
            end
        end else if (parse_cfg_wr && (parse_cfg_addr < CFG_ADDR_W'(N_CONT))) begin
            r_cfg[parse_cfg_addr] <= cfg_entry_t'(parse_cfg_data);
        end
    end

    // Container extraction; container 0 of each group sits at the group MSB
    for (genvar g = 0; g < N_C48; g++) begin : g_c48
        phv_parser_extract #(.W_BYTES(C48_BYTES), .WIN_BYTES(HDR_BYTES)) u_ext (
            .i_hdr   (r_hdr),
            .i_en    (r_cfg[g].vld),
            .i_off   (r_cfg[g].off),
            .o_field (w_c48[(N_C48-1-g)*C48_BYTES*8 +: C48_BYTES*8])
        );
    end

    for (genvar g = 0; g < N_C32; g++) begin : g_c32
        phv_parser_extract #(.W_BYTES(C32_BYTES), .WIN_BYTES(HDR_BYTES)) u_ext (
            .i_hdr   (r_hdr),
            .i_en    (r_cfg[N_C48+g].vld),
            .i_off   (r_cfg[N_C48+g].off),
            .o_field (w_c32[(N_C32-1-g)*C32_BYTES*8 +: C32_BYTES*8])
        );
    end

    for (genvar g = 0; g < N_C16; g++) begin : g_c16
        phv_parser_extract #(.W_BYTES(C16_BYTES), .WIN_BYTES(HDR_BYTES)) u_ext (
            .i_hdr   (r_hdr),
            .i_en    (r_cfg[N_C48+N_C32+g].vld),
            .i_off   (r_cfg[N_C48+N_C32+g].off),
            .o_field (w_c16[(N_C16-1-g)*C16_BYTES*8 +: C16_BYTES*8])
        );
    end

    assign w_phv = {w_c48, w_c32, w_c16, {PAD_BITS{1'b0}}, {META_Z{1'b0}}, r_len, r_tuser};

    // Output register: PHV loads only in EMIT and holds until the next packet
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            phv_out       <= '0;
            phv_valid_out <= 1'b0;
        end else begin
            phv_valid_out <= w_emit;
            if (w_emit) begin
                phv_out <= w_phv;
            end
        end
    end

endmodule

// File: tb/tb_phv_parser.sv
// Bench for phv_parser: randomized and directed packets checked every cycle
// against a byte-level packet model, plus literal checks on selected PHVs.
`timescale 1ns/1ps
module tb_phv_parser;

    localparam int PW = 1124;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [6:0]  cfg_data = '0;
    logic [PW-1:0] phv_out;
    logic        phv_valid_out;

    phv_parser_if #(.DATA_W(256), .USER_W(128)) s_axis_if ();

    phv_parser dut (
        .axis_clk       (clk),
        .aresetn        (aresetn),
        .s_axis         (s_axis_if),
        .parse_cfg_wr   (cfg_wr),
        .parse_cfg_addr (cfg_addr),
        .parse_cfg_data (cfg_data),
        .phv_out        (phv_out),
        .phv_valid_out  (phv_valid_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // ---------------- behavioural model ----------------
    bit              m_cv [24];
    int              m_co [24];
    logic [7:0]      m_bytes [64];
    int              m_len;
    logic [127:0]    m_tuser;
    int              m_beat;
    bit              m_emit;
    bit              m_live;
    bit              m_vld;
    logic [PW-1:0]   m_phv = '0;

    // observations
    int              cap_cnt = 0;
    int              cap_cyc = 0;
    logic [PW-1:0]   cap_hist [$];
    int              rdy_low = 0;
    int              last_acc = 0;

    function automatic logic [PW-1:0] model_phv();
        logic [PW-1:0] p;
        int top, w, idx;
        p = '0;
        top = PW;
        for (int k = 0; k < 24; k++) begin
            w = (k < 8) ? 6 : ((k < 16) ? 4 : 2);
            top = top - w*8;
            if (m_cv[k]) begin
                for (int j = 0; j < w; j++) begin
                    idx = m_co[k] + j;
                    if (idx < 64) p[top + (w-1-j)*8 +: 8] = m_bytes[idx];
                end
            end
        end
        p[127:0]   = m_tuser;
        p[143:128] = 16'(m_len);
        return p;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!aresetn) begin
            m_live = 0; m_emit = 0; m_beat = 0; m_vld = 0; m_phv = '0;
            for (int k = 0; k < 24; k++) begin m_cv[k] = 0; m_co[k] = 0; end
        end else begin
            bit rdy;
            int pop;
            rdy = m_live && !m_emit;
            m_vld = m_emit;
            if (m_emit) begin
                m_phv  = model_phv();
                m_emit = 0;
            end
            if (cfg_wr && cfg_addr < 5'd24) begin
                m_cv[int'(cfg_addr)] = cfg_data[6];
                m_co[int'(cfg_addr)] = int'(cfg_data[5:0]);
            end
            if (s_axis_if.tvalid && rdy) begin
                pop = $countones(s_axis_if.tkeep);
                if (m_beat == 0) begin
                    for (int i = 0; i < 64; i++) m_bytes[i] = 8'h00;
                    m_tuser = s_axis_if.tuser;
                    m_len   = 0;
                end
                if (m_beat < 2) begin
                    for (int b = 0; b < 32; b++)
                        m_bytes[m_beat*32 + b] = s_axis_if.tkeep[b] ? s_axis_if.tdata[b*8 +: 8] : 8'h00;
                end
                m_len = m_len + pop;
                if (m_len > 65535) m_len = 65535;
                m_beat++;
                if (s_axis_if.tlast) begin
                    m_emit = 1;
                    m_beat = 0;
                end
            end
            m_live = 1;
        end
    end

    // ---------------- comparison helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chkphv(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        int pos, lo;
        n_cmp++;
        if (act !== exp) begin
            pos = 0;
            for (int i = 0; i < PW; i++) if (act[i] !== exp[i]) pos = i;
            lo = (pos >= 63) ? pos - 63 : 0;
            n_fail++;
            $display("FAIL %s: highest differing bit %0d, bits [%0d+:64] got %h expected %h (cycle %0d)",
                     nm, pos, lo, act[lo +: 64], exp[lo +: 64], cyc);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (!aresetn) begin
            chk("rst_tready", 64'(s_axis_if.tready), 64'd0);
            chk("rst_phv_valid", 64'(phv_valid_out), 64'd0);
            chkphv("rst_phv_out", phv_out, '0);
        end else begin
            chk("tready", 64'(s_axis_if.tready), 64'(m_live && !m_emit));
            chk("phv_valid", 64'(phv_valid_out), 64'(m_vld));
            chkphv("phv_out", phv_out, m_phv);
            if (!s_axis_if.tready) rdy_low++;
        end
        if (phv_valid_out) begin
            cap_cnt++;
            cap_cyc = cyc;
            cap_hist.push_back(phv_out);
        end
    end

    // ---------------- stimulus ----------------
    task automatic sync();
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        repeat (n) sync();
    endtask

    task automatic cfg(input int a, input bit v, input int o);
        cfg_wr   = 1'b1;
        cfg_addr = 5'(a);
        cfg_data = {v, 6'(o)};
        sync();
        cfg_wr   = 1'b0;
    endtask

    task automatic send_beat(input logic [255:0] d, input logic [31:0] k,
                             input logic [127:0] u, input bit l);
        int guard;
        guard = 0;
        s_axis_if.tdata  = d;
        s_axis_if.tkeep  = k;
        s_axis_if.tuser  = u;
        s_axis_if.tlast  = l;
        s_axis_if.tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_axis_if.tready) break;
            guard++;
            if (guard > 100) break;
        end
        last_acc = cyc;
        if (guard > 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL beat_accept: tready stayed 0 for 100 cycles, required 1");
        end
        sync();
        s_axis_if.tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int nb, input bit rnd, input logic [31:0] klast,
                            input int gap, input logic [127:0] u);
        logic [255:0] d;
        logic [31:0]  k;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 32; i++)
                d[i*8 +: 8] = rnd ? 8'($urandom) : 8'(b*32 + i);
            if (b == nb-1) k = klast;
            else if (rnd && $urandom_range(3, 0) == 0) k = $urandom;
            else k = 32'hFFFF_FFFF;
            send_beat(d, k, u, (b == nb-1));
            if (gap > 0 && b != nb-1) idle($urandom_range(gap, 0));
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: still running at 1ms, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, r0;
        logic [PW-1:0] pa, pb;
        s_axis_if.tdata  = '0;
        s_axis_if.tkeep  = '0;
        s_axis_if.tuser  = '0;
        s_axis_if.tlast  = 1'b0;
        s_axis_if.tvalid = 1'b0;

        // reset and release
        repeat (3) @(negedge clk);
        chk("reset_tready", 64'(s_axis_if.tready), 64'd0);
        chk("reset_phv_out_lo", phv_out[63:0], 64'd0);
        sync();
        aresetn = 1'b1;
        sync();
        @(negedge clk);
        chk("release_tready", 64'(s_axis_if.tready), 64'd1);
        sync();

        // basic 2-beat packet, c0 @0, c8 @12
        cfg(0, 1, 0);
        cfg(8, 1, 12);
        c0 = cap_cnt;
        send_pkt(2, 0, 32'hFFFF_FFFF, 0, 128'hABCD);
        idle(4);
        chk("pkt1_count", 64'(cap_cnt - c0), 64'd1);
        chk("pkt1_c0", 64'(cap_hist[$][1123:1076]), 64'h0000_0001_0203_0405);
        chk("pkt1_c8", 64'(cap_hist[$][739:708]), 64'h0C0D_0E0F);
        chk("pkt1_len", 64'(cap_hist[$][143:128]), 64'd64);
        chk("pkt1_tuser", cap_hist[$][63:0], 64'hABCD);
        chk("pkt1_latency", 64'(cap_cyc - last_acc), 64'd2);
        chk("model_c0", 64'(m_phv[1123:1076]), 64'h0000_0001_0203_0405);
        chk("model_len", 64'(m_phv[143:128]), 64'd64);

        // 1-beat packet with half keep; then c17 at the window edge
        cfg(16, 1, 30);
        cfg(17, 1, 63);
        send_pkt(1, 0, 32'h0000_FFFF, 0, 128'h1);
        idle(4);
        chk("short_c16", 64'(cap_hist[$][483:468]), 64'h0);
        chk("short_len", 64'(cap_hist[$][143:128]), 64'd16);
        send_pkt(2, 0, 32'hFFFF_FFFF, 0, 128'h2);
        idle(4);
        chk("edge_c17", 64'(cap_hist[$][467:452]), 64'h3F00);
        chk("edge_c16", 64'(cap_hist[$][483:468]), 64'h1E1F);
        chk("model_c17", 64'(m_phv[467:452]), 64'h3F00);

        // 10-beat packet with gaps
        c0 = cap_cnt;
        r0 = rdy_low;
        send_pkt(10, 0, 32'hFFFF_FFFF, 3, 128'h3);
        idle(4);
        chk("long_count", 64'(cap_cnt - c0), 64'd1);
        chk("long_len", 64'(cap_hist[$][143:128]), 64'd320);
        chk("long_tready_low", 64'(rdy_low - r0), 64'd1);

        // back-to-back with config change in pkt A's EMIT cycle
        c0 = cap_cnt;
        send_pkt(2, 0, 32'hFFFF_FFFF, 0, 128'hA);
        cfg(0, 1, 10);
        send_pkt(2, 0, 32'hFFFF_FFFF, 0, 128'hB);
        idle(4);
        chk("b2b_count", 64'(cap_cnt - c0), 64'd2);
        pa = cap_hist[cap_hist.size()-2];
        pb = cap_hist[cap_hist.size()-1];
        chk("b2b_A_c0", 64'(pa[1123:1076]), 64'h0000_0001_0203_0405);
        chk("b2b_B_c0", 64'(pb[1123:1076]), 64'h0000_0A0B_0C0D_0E0F);

        // reset pulse in the middle of a 3-beat packet
        c0 = cap_cnt;
        send_beat({8{32'h5555_5555}}, 32'hFFFF_FFFF, 128'h7, 1'b0);
        send_beat({8{32'h6666_6666}}, 32'hFFFF_FFFF, 128'h7, 1'b0);
        aresetn = 1'b0;
        @(negedge clk);
        chk("midrst_tready", 64'(s_axis_if.tready), 64'd0);
        chk("midrst_valid", 64'(phv_valid_out), 64'd0);
        chk("midrst_phv_c0", 64'(phv_out[1123:1076]), 64'd0);
        sync();
        idle(1);
        aresetn = 1'b1;
        idle(4);
        chk("midrst_no_phv", 64'(cap_cnt - c0), 64'd0);
        chk("midrst_tready_back", 64'(s_axis_if.tready), 64'd1);
        cfg(0, 1, 2);
        send_pkt(2, 0, 32'hFFFF_FFFF, 0, 128'h9);
        idle(4);
        chk("postrst_count", 64'(cap_cnt - c0), 64'd1);
        chk("postrst_c0", 64'(cap_hist[$][1123:1076]), 64'h0000_0203_0405_0607);
        chk("postrst_c8_invalid", 64'(cap_hist[$][739:708]), 64'h0);
        chk("postrst_len", 64'(cap_hist[$][143:128]), 64'd64);

        // length saturation
        send_pkt(2050, 0, 32'hFFFF_FFFF, 0, 128'h5);
        idle(4);
        chk("sat_len", 64'(cap_hist[$][143:128]), 64'hFFFF);

        // randomized traffic and table updates
        for (int p = 0; p < 300; p++) begin
            if ($urandom_range(1, 0) == 1)
                cfg($urandom_range(31, 0), 1'($urandom_range(3, 0) != 0), $urandom_range(63, 0));
            send_pkt($urandom_range(5, 1), 1,
                     ($urandom_range(1, 0) == 1) ? 32'hFFFF_FFFF : $urandom,
                     $urandom_range(2, 0), rnd128());
            if ($urandom_range(3, 0) == 0)
                cfg($urandom_range(23, 0), 1'b1, $urandom_range(63, 0));
            else if ($urandom_range(3, 0) == 0)
                idle($urandom_range(3, 1));
        end
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
